// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port integer register file.
// Module parameters override the defaults; the typedefs describe the default build.
package regfile_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  typedef logic [AW-1:0]   reg_idx_t;
  typedef logic [XLEN-1:0] xword_t;

  function automatic logic is_zero_reg(input int idx);
    return idx == 0;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: cleared by writeback, set by issue (set wins on a same-cycle collision).
// Clear inputs arrive pre-qualified: only writes that actually land in the array.
module regfile_scoreboard #(
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_a_en,
  input  logic [AW-1:0]   clr_a_sel,
  input  logic            clr_b_en,
  input  logic [AW-1:0]   clr_b_sel,
  input  logic            set_en,
  input  logic [AW-1:0]   set_sel,
  input  logic [NRD*AW-1:0] rd_sel,
  output logic [NRD-1:0]  rd_busy
);
  import regfile_pkg::*;

  logic [NREGS-1:0] busy;
  logic             set_ok;

  assign set_ok = set_en && ({1'b0, set_sel} < (AW+1)'(NREGS))
                  && !(ZERO_REG && is_zero_reg(int'(set_sel)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (set_ok && set_sel == AW'(i))
          busy[i] <= 1'b1;
        else if ((clr_a_en && clr_a_sel == AW'(i)) || (clr_b_en && clr_b_sel == AW'(i)))
          busy[i] <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_port
    logic [AW-1:0] sel;
    logic          in_rng;
    logic          fresh;
    assign sel    = rd_sel[k*AW +: AW];
    assign in_rng = {1'b0, sel} < (AW+1)'(NREGS);
    // With bypass the reader already sees the value being written, so it is no longer pending.
    assign fresh  = BYPASS && ((clr_a_en && clr_a_sel == sel) || (clr_b_en && clr_b_sel == sel));
    assign rd_busy[k] = in_rng && !fresh && busy[sel];
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: NRD combinational read ports, two write ports (WB wins on collision),
// optional write-to-read bypass, busy scoreboard and a registered debug read port.
module register_file_mp #(
  parameter int XLEN     = regfile_pkg::XLEN,
  parameter int NREGS    = regfile_pkg::NREGS,
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              wa_en_i,
  input  logic [AW-1:0]     wa_sel_i,
  input  logic [XLEN-1:0]   wa_data_i,
  input  logic              wb_en_i,
  input  logic [AW-1:0]     wb_sel_i,
  input  logic [XLEN-1:0]   wb_data_i,
  input  logic              busy_set_en_i,
  input  logic [AW-1:0]     busy_set_sel_i,
  input  logic [NRD*AW-1:0] rd_sel_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]    rd_busy_o,
  input  logic [AW-1:0]     dbg_sel_i,
  output logic [XLEN-1:0]   dbg_data_o
);
  import regfile_pkg::*;

  logic [XLEN-1:0] regs [NREGS];
  logic            wa_ok;
  logic            wb_ok;

  function automatic logic in_range(input logic [AW-1:0] idx);
    return {1'b0, idx} < (AW+1)'(NREGS);
  endfunction

  function automatic logic writable(input logic en, input logic [AW-1:0] idx);
    return en && in_range(idx) && !(ZERO_REG && is_zero_reg(int'(idx)));
  endfunction

  assign wa_ok = writable(wa_en_i, wa_sel_i);
  assign wb_ok = writable(wb_en_i, wb_sel_i);

  // WB is assigned last so it wins when both ports target the same register.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      dbg_data_o <= '0;
    end else begin
      dbg_data_o <= in_range(dbg_sel_i) ? regs[dbg_sel_i] : '0;
      if (wa_ok) regs[wa_sel_i] <= wa_data_i;
      if (wb_ok) regs[wb_sel_i] <= wb_data_i;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   sel;
    logic            valid;
    logic            hit_a;
    logic            hit_b;
    logic [XLEN-1:0] data;
    assign sel   = rd_sel_i[k*AW +: AW];
    assign valid = in_range(sel) && !(ZERO_REG && is_zero_reg(int'(sel)));
    assign hit_a = BYPASS && wa_ok && (wa_sel_i == sel);
    assign hit_b = BYPASS && wb_ok && (wb_sel_i == sel);
    assign data  = !valid ? '0 :
                   hit_b  ? wb_data_i :
                   hit_a  ? wa_data_i : regs[sel];
    assign rd_data_o[k*XLEN +: XLEN] = data;
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (reset_i),
    .clr_a_en  (wa_ok),
    .clr_a_sel (wa_sel_i),
    .clr_b_en  (wb_ok),
    .clr_b_sel (wb_sel_i),
    .set_en    (busy_set_en_i),
    .set_sel   (busy_set_sel_i),
    .rd_sel    (rd_sel_i),
    .rd_busy   (rd_busy_o)
  );

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: a default build (32x32, bypass, zero reg) and a 12x64, 3-port,
// no-bypass, no-zero-reg build, both checked against an array-based reference model.
module tb_register_file_mp;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk = ~clk;

  // build 0: XLEN 32, NREGS 32, NRD 2, ZERO_REG 1, BYPASS 1
  logic        d0_wa_en, d0_wb_en, d0_bs_en;
  logic [4:0]  d0_wa_sel, d0_wb_sel, d0_bs_sel, d0_dbg_sel;
  logic [31:0] d0_wa_data, d0_wb_data, d0_dbg_data;
  logic [9:0]  d0_rd_sel;
  logic [63:0] d0_rd_data;
  logic [1:0]  d0_rd_busy;

  // build 1: XLEN 64, NREGS 12, NRD 3, ZERO_REG 0, BYPASS 0
  logic         d1_wa_en, d1_wb_en, d1_bs_en;
  logic [3:0]   d1_wa_sel, d1_wb_sel, d1_bs_sel, d1_dbg_sel;
  logic [63:0]  d1_wa_data, d1_wb_data, d1_dbg_data;
  logic [11:0]  d1_rd_sel;
  logic [191:0] d1_rd_data;
  logic [2:0]   d1_rd_busy;

  register_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut0 (
    .clk(clk), .reset_i(reset_i),
    .wa_en_i(d0_wa_en), .wa_sel_i(d0_wa_sel), .wa_data_i(d0_wa_data),
    .wb_en_i(d0_wb_en), .wb_sel_i(d0_wb_sel), .wb_data_i(d0_wb_data),
    .busy_set_en_i(d0_bs_en), .busy_set_sel_i(d0_bs_sel),
    .rd_sel_i(d0_rd_sel), .rd_data_o(d0_rd_data), .rd_busy_o(d0_rd_busy),
    .dbg_sel_i(d0_dbg_sel), .dbg_data_o(d0_dbg_data)
  );

  register_file_mp #(.XLEN(64), .NREGS(12), .NRD(3), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut1 (
    .clk(clk), .reset_i(reset_i),
    .wa_en_i(d1_wa_en), .wa_sel_i(d1_wa_sel), .wa_data_i(d1_wa_data),
    .wb_en_i(d1_wb_en), .wb_sel_i(d1_wb_sel), .wb_data_i(d1_wb_data),
    .busy_set_en_i(d1_bs_en), .busy_set_sel_i(d1_bs_sel),
    .rd_sel_i(d1_rd_sel), .rd_data_o(d1_rd_data), .rd_busy_o(d1_rd_busy),
    .dbg_sel_i(d1_dbg_sel), .dbg_data_o(d1_dbg_data)
  );

  // build descriptions used by the model
  int          c_nregs[2]  = '{32, 12};
  bit          c_zero[2]   = '{1'b1, 1'b0};
  bit          c_byp[2]    = '{1'b1, 1'b0};
  int          c_nrd[2]    = '{2, 3};
  int          c_maxsel[2] = '{31, 15};
  logic [63:0] c_mask[2]   = '{64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};

  // current-cycle stimulus per build
  bit          s_wa_en[2], s_wb_en[2], s_bs_en[2];
  int          s_wa_sel[2], s_wb_sel[2], s_bs_sel[2], s_dbg[2];
  int          s_rd[2][3];
  logic [63:0] s_wa_data[2], s_wb_data[2];

  // reference model state
  logic [63:0] m_regs[2][32];
  bit          m_busy[2][32];
  logic [63:0] m_dbg[2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[d][i] = 64'h0;
        m_busy[d][i] = 1'b0;
      end
      m_dbg[d] = 64'h0;
    end
  endtask

  function automatic bit can_write(int d, int sel);
    return (sel < c_nregs[d]) && !(c_zero[d] && sel == 0);
  endfunction

  function automatic logic [63:0] exp_rd(int d, int sel);
    if (sel >= c_nregs[d] || (c_zero[d] && sel == 0)) return 64'h0;
    if (c_byp[d] && s_wb_en[d] && s_wb_sel[d] == sel) return s_wb_data[d] & c_mask[d];
    if (c_byp[d] && s_wa_en[d] && s_wa_sel[d] == sel) return s_wa_data[d] & c_mask[d];
    return m_regs[d][sel];
  endfunction

  function automatic bit exp_busy(int d, int sel);
    if (sel >= c_nregs[d]) return 1'b0;
    if (c_byp[d] && ((s_wa_en[d] && s_wa_sel[d] == sel && can_write(d, sel)) ||
                     (s_wb_en[d] && s_wb_sel[d] == sel && can_write(d, sel)))) return 1'b0;
    return m_busy[d][sel];
  endfunction

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      m_dbg[d] = (s_dbg[d] < c_nregs[d]) ? m_regs[d][s_dbg[d]] : 64'h0;
      if (s_wa_en[d] && can_write(d, s_wa_sel[d])) begin
        m_regs[d][s_wa_sel[d]] = s_wa_data[d] & c_mask[d];
        m_busy[d][s_wa_sel[d]] = 1'b0;
      end
      if (s_wb_en[d] && can_write(d, s_wb_sel[d])) begin
        m_regs[d][s_wb_sel[d]] = s_wb_data[d] & c_mask[d];
        m_busy[d][s_wb_sel[d]] = 1'b0;
      end
      if (s_bs_en[d] && can_write(d, s_bs_sel[d])) m_busy[d][s_bs_sel[d]] = 1'b1;
    end
  endtask

  // ---------------- DUT access ----------------
  function automatic logic [63:0] rd(int d, int k);
    if (d == 0) return {32'h0, d0_rd_data[k*32 +: 32]};
    return d1_rd_data[k*64 +: 64];
  endfunction

  function automatic logic [63:0] bsy(int d, int k);
    if (d == 0) return {63'h0, d0_rd_busy[k]};
    return {63'h0, d1_rd_busy[k]};
  endfunction

  function automatic logic [63:0] dbg(int d);
    if (d == 0) return {32'h0, d0_dbg_data};
    return d1_dbg_data;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle();
    for (int d = 0; d < 2; d++) begin
      s_wa_en[d] = 1'b0; s_wb_en[d] = 1'b0; s_bs_en[d] = 1'b0;
    end
  endtask

  task automatic wr(int d, bit port_b, int sel, logic [63:0] data);
    if (port_b) begin
      s_wb_en[d] = 1'b1; s_wb_sel[d] = sel; s_wb_data[d] = data;
    end else begin
      s_wa_en[d] = 1'b1; s_wa_sel[d] = sel; s_wa_data[d] = data;
    end
  endtask

  task automatic bset(int d, int sel);
    s_bs_en[d] = 1'b1; s_bs_sel[d] = sel;
  endtask

  task automatic drive_check();
    d0_wa_en = s_wa_en[0]; d0_wa_sel = 5'(s_wa_sel[0]); d0_wa_data = s_wa_data[0][31:0];
    d0_wb_en = s_wb_en[0]; d0_wb_sel = 5'(s_wb_sel[0]); d0_wb_data = s_wb_data[0][31:0];
    d0_bs_en = s_bs_en[0]; d0_bs_sel = 5'(s_bs_sel[0]); d0_dbg_sel = 5'(s_dbg[0]);
    d0_rd_sel = {5'(s_rd[0][1]), 5'(s_rd[0][0])};
    d1_wa_en = s_wa_en[1]; d1_wa_sel = 4'(s_wa_sel[1]); d1_wa_data = s_wa_data[1];
    d1_wb_en = s_wb_en[1]; d1_wb_sel = 4'(s_wb_sel[1]); d1_wb_data = s_wb_data[1];
    d1_bs_en = s_bs_en[1]; d1_bs_sel = 4'(s_bs_sel[1]); d1_dbg_sel = 4'(s_dbg[1]);
    d1_rd_sel = {4'(s_rd[1][2]), 4'(s_rd[1][1]), 4'(s_rd[1][0])};
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < c_nrd[d]; k++) begin
        check($sformatf("d%0d_rd%0d_data", d, k), rd(d, k), exp_rd(d, s_rd[d][k]));
        check($sformatf("d%0d_rd%0d_busy", d, k), bsy(d, k), {63'h0, exp_busy(d, s_rd[d][k])});
      end
      check($sformatf("d%0d_dbg", d), dbg(d), m_dbg[d]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset_i) model_edge();
    @(negedge clk);
  endtask

  task automatic cyc();
    drive_check();
    step();
  endtask

  task automatic set_rd(int d, int s0, int s1, int s2);
    s_rd[d][0] = s0; s_rd[d][1] = s1; s_rd[d][2] = s2;
  endtask

  function automatic int rsel(int d);
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 3));
    return int'($urandom_range(0, c_maxsel[d]));
  endfunction

  localparam logic [63:0] K64 = 64'h0101_0101_0101_0101;

  // ---------------- test sequence ----------------
  initial begin
    model_reset();
    idle();
    for (int d = 0; d < 2; d++) begin
      s_wa_sel[d] = 0; s_wb_sel[d] = 0; s_bs_sel[d] = 0; s_dbg[d] = 0;
      s_wa_data[d] = 64'h0; s_wb_data[d] = 64'h0;
      set_rd(d, 1, 2, 3);
    end
    @(negedge clk);
    cyc();
    reset_i = 1'b0;
    cyc();

    // dual write, then same-index collision
    for (int d = 0; d < 2; d++) begin
      wr(d, 0, 3, 64'h11); wr(d, 1, 4, 64'h22);
    end
    cyc();
    idle();
    for (int d = 0; d < 2; d++) set_rd(d, 3, 4, 0);
    drive_check();
    for (int d = 0; d < 2; d++) begin
      check("dual_wa", rd(d, 0), 64'h11);
      check("dual_wb", rd(d, 1), 64'h22);
    end
    step();
    for (int d = 0; d < 2; d++) begin
      wr(d, 0, 7, 64'hAA); wr(d, 1, 7, 64'hBB);
    end
    cyc();
    idle();
    for (int d = 0; d < 2; d++) set_rd(d, 7, 7, 7);
    drive_check();
    for (int d = 0; d < 2; d++) check("collide_wb_wins", rd(d, 0), 64'hBB);
    step();

    // register zero
    for (int d = 0; d < 2; d++) begin
      wr(d, 0, 0, 64'hFFFF_FFFF); bset(d, 0);
    end
    cyc();
    idle();
    for (int d = 0; d < 2; d++) set_rd(d, 0, 0, 0);
    drive_check();
    check("zero_rd", rd(0, 0), 64'h0);
    check("zero_busy", bsy(0, 0), 64'h0);
    check("nozero_rd", rd(1, 0), 64'hFFFF_FFFF);
    check("nozero_busy", bsy(1, 0), 64'h1);
    step();

    // bypass
    for (int d = 0; d < 2; d++) wr(d, 0, 9, 64'h1);
    cyc();
    idle();
    for (int d = 0; d < 2; d++) begin
      wr(d, 0, 9, 64'h55); set_rd(d, 9, 9, 9);
    end
    drive_check();
    check("byp_wa", rd(0, 0), 64'h55);
    check("nobyp_wa", rd(1, 0), 64'h1);
    step();
    for (int d = 0; d < 2; d++) begin
      wr(d, 0, 9, 64'h55); wr(d, 1, 9, 64'h66);
    end
    drive_check();
    check("byp_wb_wins", rd(0, 0), 64'h66);
    check("nobyp_stored", rd(1, 0), 64'h55);
    step();
    idle();
    drive_check();
    for (int d = 0; d < 2; d++) check("after_byp", rd(d, 1), 64'h66);
    step();

    // scoreboard (x12 on build 0, x10 on build 1 which has only 12 registers)
    for (int d = 0; d < 2; d++) begin
      bset(d, d == 0 ? 12 : 10); set_rd(d, d == 0 ? 12 : 10, 1, 2);
    end
    cyc();
    idle();
    drive_check();
    for (int d = 0; d < 2; d++) check("sb_set", bsy(d, 0), 64'h1);
    step();
    for (int d = 0; d < 2; d++) begin
      wr(d, 1, s_rd[d][0], 64'h77); bset(d, s_rd[d][0]);
    end
    cyc();
    idle();
    for (int d = 0; d < 2; d++) wr(d, 0, s_rd[d][0], 64'h88);
    drive_check();
    check("sb_clr_byp", bsy(0, 0), 64'h0);
    check("sb_clr_nobyp", bsy(1, 0), 64'h1);
    step();
    idle();
    drive_check();
    for (int d = 0; d < 2; d++) check("sb_cleared", bsy(d, 0), 64'h0);
    step();

    // asynchronous reset mid-run
    for (int d = 0; d < 2; d++) begin
      wr(d, 0, 5, 64'hDEAD_BEEF); bset(d, 5); set_rd(d, 5, 5, 5); s_dbg[d] = 5;
    end
    cyc();
    idle();
    cyc();
    drive_check();
    for (int d = 0; d < 2; d++) begin
      check("pre_rst_rd", rd(d, 0), 64'hDEAD_BEEF);
      check("pre_rst_busy", bsy(d, 0), 64'h1);
      check("pre_rst_dbg", dbg(d), 64'hDEAD_BEEF);
    end
    reset_i = 1'b1;
    #1;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      check("rst_rd", rd(d, 0), 64'h0);
      check("rst_busy", bsy(d, 0), 64'h0);
      check("rst_dbg", dbg(d), 64'h0);
    end
    step();
    reset_i = 1'b0;
    cyc();
    drive_check();
    for (int d = 0; d < 2; d++) check("post_rst_rd", rd(d, 0), 64'h0);
    step();

    // fill every register with i*0x01.. and read back through all ports and debug
    for (int i = 0; i < 32; i += 2) begin
      idle();
      wr(0, 0, i, K64 * i); wr(0, 1, i + 1, K64 * (i + 1));
      if (i < 12) begin
        wr(1, 0, i, K64 * i); wr(1, 1, i + 1, K64 * (i + 1));
      end
      cyc();
    end
    idle();
    for (int i = 0; i <= 32; i++) begin
      for (int d = 0; d < 2; d++) begin
        set_rd(d, i % (c_maxsel[d] + 1), (i + 1) % (c_maxsel[d] + 1), (i + 2) % (c_maxsel[d] + 1));
        s_dbg[d] = i % (c_maxsel[d] + 1);
      end
      drive_check();
      if (i > 0 && i - 1 < 12) check("fill_dbg1", dbg(1), K64 * (i - 1));
      if (i < 12) check("fill_rd1", rd(1, 0), K64 * i);
      step();
    end

    // random regression
    for (int n = 0; n < 3000; n++) begin
      for (int d = 0; d < 2; d++) begin
        s_wa_en[d] = ($urandom_range(0, 1) == 1);
        s_wb_en[d] = ($urandom_range(0, 2) == 0);
        s_bs_en[d] = ($urandom_range(0, 2) == 0);
        s_wa_sel[d] = rsel(d); s_wb_sel[d] = rsel(d); s_bs_sel[d] = rsel(d);
        s_wa_data[d] = {$urandom, $urandom}; s_wb_data[d] = {$urandom, $urandom};
        s_dbg[d] = rsel(d);
        for (int k = 0; k < 3; k++) begin
          case ($urandom_range(0, 3))
            0: s_rd[d][k] = s_wa_sel[d];
            1: s_rd[d][k] = s_wb_sel[d];
            default: s_rd[d][k] = rsel(d);
          endcase
        end
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
